fp16_alu_arbiter: RTL and testbench

FP16_ALU_ARBITER -- requirements
Module: fp16_alu_arbiter

---
 rtl/fp_alu_pkg.sv | 27 ++
 rtl/rr_priority_sel.sv | 37 +++
 rtl/fp16_alu_arbiter.sv | 155 +++++++++++++++
 tb/tb_fp16_alu_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared definitions for the FP16 ALU arbiter.
//   FP16_W / OPMODE_W : datapath widths
//   FP16_QNAN         : canonical quiet NaN returned on a watchdog timeout
//   arb_state_t       : arbiter FSM encoding
//   fp_op_t           : one latched ALU request (opmode + three operands)
package fp_alu_pkg;

  localparam int FP16_W   = 16;
  localparam int OPMODE_W = 6;

  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  typedef struct packed {
    logic [OPMODE_W-1:0] opmode;
    logic [FP16_W-1:0]   a;
    logic [FP16_W-1:0]   b;
    logic [FP16_W-1:0]   c;
  } fp_op_t;

endpackage

// File: rtl/rr_priority_sel.sv
// Rotating-priority selector: picks the first asserted request at or after
// ptr, wrapping from N-1 back to 0.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant (all zero when no request)
//   idx   : binary index of the granted request
//   any   : at least one request is asserted
module rr_priority_sel #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    // Walk the N positions starting at ptr; the first hit wins.
    for (int i = 0; i < N; i++) begin
      c = int'(ptr) + i;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any      = 1'b1;
        idx      = IW'(c);
        grant[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_alu_arbiter.sv
// Round-robin arbiter sharing one FP16 ALU between NUM_REQ requesters.
// Exactly one operation is in flight: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//
// Ports:
//   clk, rst (async, active low)
//   req_valid / req_ready            : per-requester request and one-hot accept
//   req_a/b/c, req_opmode            : per-requester operands, lane i at [16i+15:16i]
//   resp_valid / resp_data / resp_error : one-hot result strobe, shared result, timeout flag
//   alu_in_valid, alu_opmode, alu_a/b/c : issue side of the FP16 ALU
//   alu_out, alu_out_valid           : ALU result
//   busy                             : FSM not in IDLE
//
// Build option: define FP_ARB_TIMEOUT_EN to enable the WAIT watchdog, which
// returns FP16_QNAN with resp_error=1 after TIMEOUT_CYCLES WAIT cycles.
module fp16_alu_arbiter
  import fp_alu_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][FP16_W-1:0]      req_a,
  input  logic [NUM_REQ-1:0][FP16_W-1:0]      req_b,
  input  logic [NUM_REQ-1:0][FP16_W-1:0]      req_c,
  input  logic [NUM_REQ-1:0][OPMODE_W-1:0]    req_opmode,
  output logic [NUM_REQ-1:0]                  resp_valid,
  output logic [FP16_W-1:0]                   resp_data,
  output logic                                resp_error,
  output logic                                alu_in_valid,
  output logic [OPMODE_W-1:0]                 alu_opmode,
  output logic [FP16_W-1:0]                   alu_a,
  output logic [FP16_W-1:0]                   alu_b,
  output logic [FP16_W-1:0]                   alu_c,
  input  logic [FP16_W-1:0]                   alu_out,
  input  logic                                alu_out_valid,
  output logic                                busy
);

  localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [NUM_REQ-1:0] GNT0    = NUM_REQ'(1);
  localparam logic [IDXW-1:0]    LAST_IX = IDXW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fp16_alu_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fp16_alu_arbiter: TIMEOUT_CYCLES must be >= 1");
  end

  arb_state_t        state;
  logic [IDXW-1:0]   rr_ptr;
  logic [IDXW-1:0]   gnt_idx;
  fp_op_t            op_q;

  logic [NUM_REQ-1:0] sel_gnt;
  logic [IDXW-1:0]    sel_idx;
  logic               sel_any;

  rr_priority_sel #(
    .N  (NUM_REQ),
    .IW (IDXW)
  ) u_sel (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (sel_gnt),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Accept is combinational so the requester sees it in its request cycle.
  assign req_ready  = (state == ST_IDLE) ? sel_gnt : '0;
  assign busy       = (state != ST_IDLE);
  assign alu_opmode = op_q.opmode;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;
  assign alu_c      = op_q.c;

`ifdef FP_ARB_TIMEOUT_EN
  localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);
  logic [WDW-1:0] wdog;
  logic           resp_error_q;
  assign resp_error = resp_error_q;
`else
  assign resp_error = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      rr_ptr       <= '0;
      gnt_idx      <= '0;
      op_q         <= '0;
      alu_in_valid <= 1'b0;
      resp_valid   <= '0;
      resp_data    <= '0;
`ifdef FP_ARB_TIMEOUT_EN
      wdog         <= '0;
      resp_error_q <= 1'b0;
`endif
    end else begin
      alu_in_valid <= 1'b0;
      resp_valid   <= '0;
      unique case (state)
        ST_IDLE: begin
          if (sel_any) begin
            op_q.opmode  <= req_opmode[sel_idx];
            op_q.a       <= req_a[sel_idx];
            op_q.b       <= req_b[sel_idx];
            op_q.c       <= req_c[sel_idx];
            gnt_idx      <= sel_idx;
            alu_in_valid <= 1'b1;   // high for the single ISSUE cycle
            state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
`ifdef FP_ARB_TIMEOUT_EN
          wdog  <= '0;
`endif
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // alu_out_valid is only honoured here; stray pulses elsewhere drop.
          if (alu_out_valid) begin
            resp_data  <= alu_out;
            resp_valid <= GNT0 << gnt_idx;
`ifdef FP_ARB_TIMEOUT_EN
            resp_error_q <= 1'b0;
`endif
            state      <= ST_RESP;
          end
`ifdef FP_ARB_TIMEOUT_EN
          else if (wdog == WD_LAST) begin
            resp_data    <= FP16_QNAN;
            resp_error_q <= 1'b1;
            resp_valid   <= GNT0 << gnt_idx;
            state        <= ST_RESP;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          rr_ptr <= (gnt_idx == LAST_IX) ? '0 : gnt_idx + 1'b1;
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_alu_arbiter.sv
// Directed bench for fp16_alu_arbiter. The bench plays the ALU itself,
// answering one cycle after the issue cycle with a hand-computed result.
module tb_fp16_alu_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 8;

  logic                 clk;
  logic                 rst;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][15:0]  req_a, req_b, req_c;
  logic [NR-1:0][5:0]   req_opmode;
  logic [NR-1:0]        resp_valid;
  logic [15:0]          resp_data;
  logic                 resp_error;
  logic                 alu_in_valid;
  logic [5:0]           alu_opmode;
  logic [15:0]          alu_a, alu_b, alu_c;
  logic [15:0]          alu_out;
  logic                 alu_out_valid;
  logic                 busy;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  fp16_alu_arbiter #(
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_a         (req_a),
    .req_b         (req_b),
    .req_c         (req_c),
    .req_opmode    (req_opmode),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .resp_error    (resp_error),
    .alu_in_valid  (alu_in_valid),
    .alu_opmode    (alu_opmode),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_c         (alu_c),
    .alu_out       (alu_out),
    .alu_out_valid (alu_out_valid),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  // One full transaction, entered and left on a negedge in IDLE.
  task automatic op(input logic [NR-1:0] vld, input int gi, input logic [15:0] ret,
                    input logic drop, input string tag);
    req_valid = vld;
    #1;
    chk({tag, ".ready"}, req_ready, oh(gi));
    @(negedge clk);                                  // ISSUE
    if (drop) req_valid = '0;
    chk({tag, ".in_valid"}, alu_in_valid, 1'b1);
    chk({tag, ".alu_a"}, alu_a, req_a[gi]);
    chk({tag, ".alu_b"}, alu_b, req_b[gi]);
    chk({tag, ".alu_c"}, alu_c, req_c[gi]);
    chk({tag, ".alu_op"}, alu_opmode, req_opmode[gi]);
    chk({tag, ".ready_issue"}, req_ready, '0);
    chk({tag, ".busy"}, busy, 1'b1);
    @(negedge clk);                                  // WAIT
    chk({tag, ".in_valid_off"}, alu_in_valid, 1'b0);
    alu_out_valid = 1'b1;
    alu_out       = ret;
    @(negedge clk);                                  // RESP
    alu_out_valid = 1'b0;
    alu_out       = 16'hDEAD;
    chk({tag, ".resp_valid"}, resp_valid, oh(gi));
    chk({tag, ".resp_data"}, resp_data, ret);
    chk({tag, ".resp_error"}, resp_error, 1'b0);
    @(negedge clk);                                  // IDLE
    chk({tag, ".resp_off"}, resp_valid, '0);
    chk({tag, ".hold"}, resp_data, ret);
  endtask

  initial begin
    rst           = 1'b0;
    req_valid     = '0;
    alu_out       = '0;
    alu_out_valid = 1'b0;
    for (int i = 0; i < NR; i++) begin
      req_a[i]      = 16'h1000 + 16'(i);
      req_b[i]      = 16'h2000 + 16'(i);
      req_c[i]      = 16'h3000 + 16'(i);
      req_opmode[i] = 6'(i + 1);
    end
    // Requester 2: a=3.75, b=1.5, c=3.875, opmode 0; fused a*b+c = 9.5
    req_a[2]      = 16'h4380;
    req_b[2]      = 16'h3E00;
    req_c[2]      = 16'h43C0;
    req_opmode[2] = 6'd0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy", busy, 1'b0);
    chk("rst.resp_valid", resp_valid, '0);
    chk("rst.resp_data", resp_data, 16'h0000);
    chk("rst.resp_error", resp_error, 1'b0);
    chk("rst.in_valid", alu_in_valid, 1'b0);
    chk("rst.alu_a", alu_a, 16'h0000);
    chk("rst.req_ready", req_ready, '0);
    rst = 1'b1;
    @(negedge clk);

    // All four held: grants 0,1,2,3,0 one IDLE cycle apart
    op(4'b1111, 0, 16'hA000, 1'b0, "rr0");
    op(4'b1111, 1, 16'hA001, 1'b0, "rr1");
    op(4'b1111, 2, 16'hA002, 1'b0, "rr2");
    op(4'b1111, 3, 16'hA003, 1'b0, "rr3");
    op(4'b1111, 0, 16'hA004, 1'b0, "rr4");
    req_valid = '0;

    // Single request from requester 2, dropped after grant (ptr 1 -> 2)
    op(4'b0100, 2, 16'h48C0, 1'b1, "single");

    // ptr=3: req 0010 wraps to 1, leaving ptr=2
    op(4'b0010, 1, 16'h1111, 1'b0, "wrap_a");
    // ptr=2 with 1010: grant 3, then 1
    op(4'b1010, 3, 16'h3333, 1'b0, "ptr2_g3");
    op(4'b1010, 1, 16'h5555, 1'b0, "ptr2_g1");
    req_valid = '0;

    // Stray alu_out_valid in IDLE is ignored
    alu_out_valid = 1'b1;
    alu_out       = 16'h1234;
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("stray.resp_valid", resp_valid, '0);
    chk("stray.busy", busy, 1'b0);
    @(negedge clk);
    chk("stray.resp_valid2", resp_valid, '0);
    chk("stray.data", resp_data, 16'h5555);

    // Reset during WAIT (ptr=2 -> grant 2), late ALU result ignored
    req_valid = 4'b1111;
    #1;
    chk("rstw.ready", req_ready, 4'b0100);
    @(negedge clk);                                  // ISSUE
    req_valid = '0;
    @(negedge clk);                                  // WAIT
    rst = 1'b0;
    #1;
    chk("rstw.busy", busy, 1'b0);
    chk("rstw.data", resp_data, 16'h0000);
    chk("rstw.alu_a", alu_a, 16'h0000);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    alu_out_valid = 1'b1;
    alu_out       = 16'h7777;
    @(negedge clk);
    alu_out_valid = 1'b0;
    chk("rstw.late_resp", resp_valid, '0);
    chk("rstw.late_busy", busy, 1'b0);
    chk("rstw.late_data", resp_data, 16'h0000);
    op(4'b1111, 0, 16'h6666, 1'b0, "post_rst");
    req_valid = '0;

`ifdef FP_ARB_TIMEOUT_EN
    // ALU never answers: QNaN with error after TMO WAIT cycles (ptr=1 -> grant 0)
    req_valid = 4'b0001;
    #1;
    chk("tmo.ready", req_ready, 4'b0001);
    @(negedge clk);                                  // ISSUE
    req_valid = '0;
    for (int k = 0; k < TMO; k++) begin
      @(negedge clk);                                // WAIT cycles
      chk("tmo.wait_no_resp", resp_valid, '0);
    end
    @(negedge clk);                                  // RESP
    chk("tmo.resp_valid", resp_valid, 4'b0001);
    chk("tmo.resp_data", resp_data, 16'h7E00);
    chk("tmo.resp_error", resp_error, 1'b1);
    @(negedge clk);
    chk("tmo.busy", busy, 1'b0);
    op(4'b0010, 1, 16'h4242, 1'b0, "tmo_clear");
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
